// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states,
// requester id type and the ALU opcode map used by the external ALU.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_BNE   = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1101;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational: the caller holds the
// last-grant history and decides when a grant may be issued (enable_i).
module rr_arbiter2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    input  logic       enable_i,
    output logic [1:0] grant_o
);

    // One-hot grant; on contention the requester not granted last wins.
    always_comb begin
        grant_o = 2'b00;
        if (!enable_i) begin
            grant_o = 2'b00;
        end else if (valid0_i && valid1_i) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end else if (valid0_i) begin
            grant_o = 2'b01;
        end else if (valid1_i) begin
            grant_o = 2'b10;
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. One
// operation is in flight at a time: accept (IDLE) -> capture result (EXEC)
// -> hold response until consumed (RESP).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_data,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_data,
    output logic                     busy
);

    arb_state_e                 state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    req_id_t                    owner_q, owner_d;
    logic [DATA_WIDTH-1:0]      srca_q, srca_d;
    logic [DATA_WIDTH-1:0]      srcb_q, srcb_d;
    logic [OPCODE_LENGTH-1:0]   op_q, op_d;
    logic [DATA_WIDTH-1:0]      result_q, result_d;

    logic [1:0]                 grant_s;
    logic                       accept_s;
    logic                       rsp_hs_s;

    // Grants are only offered while idle, so ready never rises mid-flight.
    rr_arbiter2 u_rr (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (state_q == ST_IDLE),
        .grant_o      (grant_s)
    );

    assign accept_s = grant_s[0] | grant_s[1];
    assign rsp_hs_s = (state_q == ST_RESP) &&
                      ((owner_q == 1'b0) ? rsp0_ready : rsp1_ready);

    // Next-state and datapath capture; everything holds unless its phase acts.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        op_d         = op_q;
        result_d     = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_EXEC;
                    owner_d      = grant_s[1];
                    last_grant_d = grant_s[1];
                    srca_d       = grant_s[1] ? req1_srca : req0_srca;
                    srcb_d       = grant_s[1] ? req1_srcb : req0_srcb;
                    op_d         = grant_s[1] ? req1_op   : req0_op;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                // Returning to IDLE a cycle later keeps accept and
                // response handshakes in different cycles.
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            srca_q       <= '0;
            srcb_q       <= '0;
            op_q         <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            op_q         <= op_d;
            result_q     <= result_d;
        end
    end

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    assign alu_srca = srca_q;
    assign alu_srcb = srcb_q;
    assign alu_op   = op_q;

    assign rsp0_valid = (state_q == ST_RESP) && (owner_q == 1'b0);
    assign rsp1_valid = (state_q == ST_RESP) && (owner_q == 1'b1);
    assign rsp0_data  = rsp0_valid ? result_q : '0;
    assign rsp1_data  = rsp1_valid ? result_q : '0;

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single transactions, hand-written
// contention / stall / reset / back-to-back sequences, then random traffic,
// all checked cycle by cycle against a transaction-level model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [OW-1:0] req0_op, req1_op, alu_op;
    logic [DW-1:0] alu_srca, alu_srcb, alu_result;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, busy;
    logic [DW-1:0] rsp0_data, rsp1_data;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
        .alu_result(alu_result),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    // External ALU model.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_BNE:   return (a != b) ? 32'd1 : 32'd0;
            ALU_PASSB: return b;
            default:   return 32'd0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_srca, alu_srcb, alu_op);

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction-level reference: one op in flight, response two cycles after accept.
    bit          m_infl;
    int          m_acc;
    bit          m_own;
    bit          m_last;
    logic [31:0] m_a, m_b, m_data;
    logic [3:0]  m_op;

    logic        obs_r [2];
    logic        obs_v [2];
    logic [31:0] obs_d [2];
    logic        obs_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at posedge+1 with inputs applied; checks, advances model, waits one clock.
    task automatic cycle();
        bit gv, g, rv0, rv1;
        #1;
        obs_r[0] = req0_ready; obs_r[1] = req1_ready;
        obs_v[0] = rsp0_valid; obs_v[1] = rsp1_valid;
        obs_d[0] = rsp0_data;  obs_d[1] = rsp1_data;
        obs_busy = busy;
        gv = 1'b0; g = 1'b0;
        if (!m_infl) begin
            if (req0_valid && req1_valid) begin gv = 1'b1; g = ~m_last; end
            else if (req0_valid) begin gv = 1'b1; g = 1'b0; end
            else if (req1_valid) begin gv = 1'b1; g = 1'b1; end
        end
        rv0 = m_infl && (cyc >= m_acc + 2) && (m_own == 1'b0);
        rv1 = m_infl && (cyc >= m_acc + 2) && (m_own == 1'b1);
        chk("req0_ready", req0_ready, gv && !g);
        chk("req1_ready", req1_ready, gv && g);
        chk("rsp0_valid", rsp0_valid, rv0);
        chk("rsp1_valid", rsp1_valid, rv1);
        chk("rsp0_data", rsp0_data, rv0 ? m_data : 32'd0);
        chk("rsp1_data", rsp1_data, rv1 ? m_data : 32'd0);
        chk("busy", busy, m_infl);
        if (m_infl) begin
            chk("alu_op", alu_op, m_op);
            chk("alu_srca", alu_srca, m_a);
            chk("alu_srcb", alu_srcb, m_b);
        end
        if (reset) begin
            m_infl = 1'b0;
            m_last = 1'b1;
        end else if (gv) begin
            m_infl = 1'b1;
            m_acc  = cyc;
            m_own  = g;
            m_last = g;
            m_a    = g ? req1_srca : req0_srca;
            m_b    = g ? req1_srcb : req0_srcb;
            m_op   = g ? req1_op   : req0_op;
            m_data = alu_fn(m_a, m_b, m_op);
        end else if ((rv0 && rsp0_ready) || (rv1 && rsp1_ready)) begin
            m_infl = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_srca = a; req0_srcb = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_srca = a; req1_srcb = b;
        end
    endtask

    typedef struct {
        int          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        bit found, other_seen;
        int lat, nacc, cnt;
        logic [31:0] dat;
        int acc_cyc [$];
        int acc_id  [$];

        vecs[0] = '{0, 4'b0010, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{0, 4'b0110, 32'd10,         32'd3,          32'd7};
        vecs[2] = '{1, 4'b0000, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030};
        vecs[3] = '{1, 4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[4] = '{1, 4'b1111, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[5] = '{0, 4'b0001, 32'h0000_0F00,  32'h0000_00F0,  32'h0000_0FF0};
        vecs[6] = '{1, 4'b1101, 32'h0000_1234,  32'h0000_ABCD,  32'h0000_ABCD};
        vecs[7] = '{0, 4'b1010, 32'd5,          32'd5,          32'd0};
        vecs[8] = '{1, 4'b1010, 32'd5,          32'd6,          32'd1};
        vecs[9] = '{0, 4'b0101, 32'd1,          32'hFFFF_FFFF,  32'd0};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_srca = '0; req0_srcb = '0; req0_op = '0;
        req1_srca = '0; req1_srcb = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        m_infl = 1'b0; m_last = 1'b1; m_acc = 0; m_own = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_data = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_req0_ready", req0_ready, 1'b0);
        chk("reset_req1_ready", req1_ready, 1'b0);
        chk("reset_rsp0_valid", rsp0_valid, 1'b0);
        chk("reset_rsp1_valid", rsp1_valid, 1'b0);
        chk("reset_alu_srca", alu_srca, 32'd0);
        chk("reset_alu_srcb", alu_srcb, 32'd0);
        chk("reset_alu_op", alu_op, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single transactions from the table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            cycle();
            chk("vec_accept", obs_r[vecs[i].id], 1'b1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            found = 1'b0; other_seen = 1'b0; lat = 0; dat = '0;
            for (int k = 0; k < 6; k++) begin
                cycle();
                if (obs_v[1 - vecs[i].id]) other_seen = 1'b1;
                if (obs_v[vecs[i].id]) begin
                    found = 1'b1; lat = k + 1; dat = obs_d[vecs[i].id];
                    break;
                end
            end
            chk("vec_found", found, 1'b1);
            chk("vec_latency", lat, 32'd2);
            chk("vec_data", dat, vecs[i].exp);
            chk("vec_other_rsp", other_seen, 1'b0);
        end

        // Contention after reset, then a stalled response for requester 1.
        reset = 1'b1; cycle(); cycle(); reset = 1'b0;
        drive(0, 4'b0110, 32'd10, 32'd3);
        drive(1, 4'b0000, 32'h0000_00F0, 32'h0000_003C);
        cycle();
        chk("cont_first_r0", obs_r[0], 1'b1);
        chk("cont_first_r1", obs_r[1], 1'b0);
        req0_valid = 1'b0;
        cycle();
        cycle();
        chk("cont_rsp0_valid", obs_v[0], 1'b1);
        chk("cont_rsp0_data", obs_d[0], 32'd7);
        cycle();
        chk("cont_second_r1", obs_r[1], 1'b1);
        req1_valid = 1'b0; rsp1_ready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'(k), $urandom, $urandom);
            drive(1, 4'(k), $urandom, $urandom);
            cycle();
            chk("stall_rsp1_valid", obs_v[1], 1'b1);
            chk("stall_rsp1_data", obs_d[1], 32'h0000_0030);
            chk("stall_r0", obs_r[0], 1'b0);
            chk("stall_r1", obs_r[1], 1'b0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b1;
        cycle();
        drive(0, 4'b0010, 32'd1, 32'd2);
        drive(1, 4'b0010, 32'd3, 32'd4);
        cycle();
        chk("cont_third_r0", obs_r[0], 1'b1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cycle();

        // Reset while the operation is in EXEC.
        drive(0, 4'b0010, 32'd1, 32'd1);
        cycle();
        chk("rexec_accept", obs_r[0], 1'b1);
        req0_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("rexec_busy", obs_busy, 1'b0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (obs_v[0]) cnt++;
        end
        chk("rexec_no_rsp", cnt, 32'd0);

        // Back-to-back contention with responses always consumed.
        drive(0, 4'b0010, 32'd100, 32'd1);
        drive(1, 4'b0110, 32'd100, 32'd1);
        for (int k = 0; k < 12; k++) begin
            int c0;
            c0 = cyc;
            cycle();
            if (obs_r[0] || obs_r[1]) begin
                acc_cyc.push_back(c0);
                acc_id.push_back(obs_r[1] ? 1 : 0);
            end
        end
        nacc = acc_cyc.size();
        chk("b2b_count", nacc, 32'd4);
        for (int i = 0; i < nacc; i++) begin
            chk("b2b_grant", acc_id[i], i % 2);
            if (i > 0) chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], 32'd3);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cycle();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_op    = 4'($urandom); req1_op = 4'($urandom);
            req0_srca  = $urandom; req0_srcb = $urandom;
            req1_srca  = $urandom; req1_srcb = $urandom;
            rsp0_ready = $urandom_range(0, 9) < 7;
            rsp1_ready = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
